// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter_pkg
//  Description : Shared widths, state encodings and helpers for ram_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package ram_arbiter_pkg;

    localparam int   BIT_DATA          = 16;
    localparam int   SZB_RAM           = 8;
    localparam int   RAM_ARB_MAX_BURST = 8;
    localparam logic OFF               = 1'b0;

    typedef enum logic [1:0] {
        RAM_ARB_IDLE = 2'b00,
        RAM_ARB_OWN0 = 2'b01,
        RAM_ARB_OWN1 = 2'b10
    } ram_arb_state_e;

    function automatic ram_arb_state_e own_of(input logic port);
        return port ? RAM_ARB_OWN1 : RAM_ARB_OWN0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arb_mux.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_mux
//  Description : Drives the shared RAM bus from whichever port has a beat
//                accepted this cycle; idles the bus at zero otherwise.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_arb_mux
    import ram_arbiter_pkg::*;
#(
    parameter int BIT = BIT_DATA,
    parameter int SZB = SZB_RAM
) (
    input  logic           beat0_i,
    input  logic           beat1_i,
    input  logic           we0_i,
    input  logic           we1_i,
    input  logic [SZB-1:0] addr0_i,
    input  logic [SZB-1:0] addr1_i,
    input  logic [BIT-1:0] d0_i,
    input  logic [BIT-1:0] d1_i,
    output logic           ram_we_o,
    output logic [SZB-1:0] ram_addr_o,
    output logic [BIT-1:0] ram_d_o
);

    always_comb begin
        ram_we_o   = OFF;
        ram_addr_o = '0;
        ram_d_o    = '0;
        if (beat0_i) begin
            ram_we_o   = we0_i;
            ram_addr_o = addr0_i;
            ram_d_o    = d0_i;
        end else if (beat1_i) begin
            ram_we_o   = we1_i;
            ram_addr_o = addr1_i;
            ram_d_o    = d1_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Two-port burst arbiter for the single-port data RAM,
//                round-robin with a burst cap. Define RAM_ARB_FIXED_PRIO_EN
//                to give port 0 absolute priority (cap applies to port 1 only).
//  Revision    : 1.0  initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int BIT       = BIT_DATA,
    parameter int SZB       = SZB_RAM,
    parameter int MAX_BURST = RAM_ARB_MAX_BURST
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req0,
    input  logic           we0,
    input  logic [SZB-1:0] addr0,
    input  logic [BIT-1:0] d0,
    output logic           gnt0,
    output logic [BIT-1:0] q0,
    output logic           vld0,
    input  logic           req1,
    input  logic           we1,
    input  logic [SZB-1:0] addr1,
    input  logic [BIT-1:0] d1,
    output logic           gnt1,
    output logic [BIT-1:0] q1,
    output logic           vld1,
    output logic           ram_we,
    output logic [SZB-1:0] ram_addr,
    output logic [BIT-1:0] ram_d,
    input  logic [BIT-1:0] ram_q
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    localparam int             CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    ram_arb_state_e   state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld0_q, vld1_q;
    logic             beat0, beat1;
    logic             cap0, cap1;
    logic             win;

    assign gnt0  = (state_q == RAM_ARB_OWN0);
    assign gnt1  = (state_q == RAM_ARB_OWN1);
    assign beat0 = req0 & gnt0;
    assign beat1 = req1 & gnt1;

    // Owner holding req implies a beat this cycle, so the cap only needs the count.
    assign cap0 = !FIXED_PRIO && req1 && (cnt_q == CNT_LAST);
    assign cap1 = req0 && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        win     = FIXED_PRIO ? 1'b0 : rr_q;
        case (state_q)
            RAM_ARB_IDLE: begin
                cnt_d = '0;
                if (req0 && req1) begin
                    state_d = own_of(win);
                    rr_d    = ~win;
                end else if (req0) begin
                    state_d = RAM_ARB_OWN0;
                    rr_d    = 1'b1;
                end else if (req1) begin
                    state_d = RAM_ARB_OWN1;
                    rr_d    = 1'b0;
                end
            end
            RAM_ARB_OWN0: begin
                if (!req0 || cap0) begin
                    state_d = req1 ? RAM_ARB_OWN1 : RAM_ARB_IDLE;
                    rr_d    = req1 ? 1'b0 : rr_q;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RAM_ARB_OWN1: begin
                if (!req1 || cap1) begin
                    state_d = req0 ? RAM_ARB_OWN0 : RAM_ARB_IDLE;
                    rr_d    = req0 ? 1'b1 : rr_q;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RAM_ARB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RAM_ARB_IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            vld0_q  <= beat0 & ~we0;
            vld1_q  <= beat1 & ~we1;
        end
    end

    assign vld0 = vld0_q;
    assign vld1 = vld1_q;
    assign q0   = ram_q;
    assign q1   = ram_q;

    ram_arb_mux #(
        .BIT (BIT),
        .SZB (SZB)
    ) u_mux (
        .beat0_i    (beat0),
        .beat1_i    (beat1),
        .we0_i      (we0),
        .we1_i      (we1),
        .addr0_i    (addr0),
        .addr1_i    (addr1),
        .d0_i       (d0),
        .d1_i       (d1),
        .ram_we_o   (ram_we),
        .ram_addr_o (ram_addr),
        .ram_d_o    (ram_d)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Directed vector bench for ram_arbiter (MAX_BURST=4) with a
//                behavioural one-cycle-latency RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

    logic        clock, reset;
    logic        req0, we0, req1, we1;
    logic [7:0]  addr0, addr1, ram_addr;
    logic [15:0] d0, d1, q0, q1, ram_d, ram_q;
    logic        gnt0, gnt1, vld0, vld1, ram_we;

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    ram_arbiter #(.BIT(16), .SZB(8), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .d0(d0), .gnt0(gnt0), .q0(q0), .vld0(vld0),
        .req1(req1), .we1(we1), .addr1(addr1), .d1(d1), .gnt1(gnt1), .q1(q1), .vld1(vld1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    typedef struct {
        logic r0, w0; logic [7:0] a0; logic [15:0] d0;
        logic r1, w1; logic [7:0] a1; logic [15:0] d1;
        logic g0, g1, v0, v1, we; logic [7:0] addr; logic [15:0] wd; logic [15:0] q;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, input logic [15:0] dd0,
                                input logic r1, w1, input logic [7:0] a1, input logic [15:0] dd1,
                                input logic g0, g1, v0, v1, we, input logic [7:0] addr,
                                input logic [15:0] wd, q);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = dd0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = dd1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
        v.we = we; v.addr = addr; v.wd = wd; v.q = q;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    vec_t tbl [17];
    int   beats, g1cnt;
    logic seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        ram_q = 16'h0;
        reset = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; d0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; d1 = 0;

        // Collision / no-bubble handover, then port-0 write/readback.
        tbl[0]  = mk(1,1,8'h20,16'h1111, 1,1,8'h20,16'h2222, 0,0,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[1]  = mk(1,1,8'h20,16'h1111, 1,1,8'h20,16'h2222, 1,0,0,0, 1,8'h20,16'h1111,16'h0);
        tbl[2]  = mk(1,1,8'h20,16'h1111, 1,1,8'h20,16'h2222, 1,0,0,0, 1,8'h20,16'h1111,16'h0);
        tbl[3]  = mk(0,0,8'h00,16'h0000, 1,1,8'h20,16'h2222, 1,0,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[4]  = mk(0,0,8'h00,16'h0000, 1,1,8'h20,16'h2222, 0,1,0,0, 1,8'h20,16'h2222,16'h0);
        tbl[5]  = mk(0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 0,1,0,0, 0,8'h20,16'h0000,16'h0);
        tbl[6]  = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,1,0,1, 0,8'h00,16'h0000,16'h2222);
        tbl[7]  = mk(1,0,8'h20,16'h0000, 1,0,8'h20,16'h0000, 0,0,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[8]  = mk(1,0,8'h20,16'h0000, 1,0,8'h20,16'h0000, 1,0,0,0, 0,8'h20,16'h0000,16'h0);
        tbl[9]  = mk(0,0,8'h00,16'h0000, 1,0,8'h20,16'h0000, 1,0,1,0, 0,8'h00,16'h0000,16'h2222);
        tbl[10] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,1,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[11] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[12] = mk(1,1,8'h10,16'hBEEF, 0,0,8'h00,16'h0000, 0,0,0,0, 0,8'h00,16'h0000,16'h0);
        tbl[13] = mk(1,1,8'h10,16'hBEEF, 0,0,8'h00,16'h0000, 1,0,0,0, 1,8'h10,16'hBEEF,16'h0);
        tbl[14] = mk(1,0,8'h10,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0, 0,8'h10,16'h0000,16'h0);
        tbl[15] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 1,0,1,0, 0,8'h00,16'h0000,16'hBEEF);
        tbl[16] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0, 0,8'h00,16'h0000,16'h0);

        #12;
        chk("reset gnt0", gnt0, 0);
        chk("reset gnt1", gnt1, 0);
        chk("reset vld0", vld0, 0);
        chk("reset vld1", vld1, 0);
        chk("reset ram_we", ram_we, 0);
        step();
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; d0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; d1 = tbl[i].d1;
            @(negedge clock);
            chk($sformatf("row%0d gnt0", i), gnt0, tbl[i].g0);
            chk($sformatf("row%0d gnt1", i), gnt1, tbl[i].g1);
            chk($sformatf("row%0d vld0", i), vld0, tbl[i].v0);
            chk($sformatf("row%0d vld1", i), vld1, tbl[i].v1);
            chk($sformatf("row%0d ram_we", i), ram_we, tbl[i].we);
            chk($sformatf("row%0d ram_addr", i), ram_addr, tbl[i].addr);
            chk($sformatf("row%0d ram_d", i), ram_d, tbl[i].wd);
            if (tbl[i].v0) chk($sformatf("row%0d q0", i), q0, tbl[i].q);
            if (tbl[i].v1) chk($sformatf("row%0d q1", i), q1, tbl[i].q);
            step();
        end

        // Burst cap: port 1 read burst, port 0 contends from its first beat.
        req1 = 1; we1 = 0; addr1 = 8'h10;
        @(negedge clock);
        chk("burst idle gnt1", gnt1, 0);
        step();
        req0 = 1; we0 = 0; addr0 = 8'h20; d0 = 0;
        beats = 0;
        seen  = 1'b0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clock);
            if (gnt0 && gnt1) begin
                errors++;
                $display("FAIL burst both grants: gnt0=%0b gnt1=%0b required one-hot", gnt0, gnt1);
            end
            if (gnt0) seen = 1'b1;
            else begin
                if (gnt1 && req1) beats++;
                step();
            end
        end
        chk("burst beats", beats, 4);
        chk("burst handover", seen, 1);
        step();
        @(negedge clock);
        chk("preempt gnt0", gnt0, 1);
        chk("preempt vld0", vld0, 1);
        chk("preempt q0", q0, 16'h2222);
        step();
        req0 = 0;
        @(negedge clock);
        chk("release ram_we", ram_we, 0);
        step();
        @(negedge clock);
        chk("resume gnt1", gnt1, 1);

        // Reset during an OWN1 cycle with a pending read result and a write beat.
        step();
        we1 = 1; d1 = 16'h5555; addr1 = 8'h30;
        @(negedge clock);
        chk("pre-reset vld1", vld1, 1);
        chk("pre-reset q1", q1, 16'hBEEF);
        chk("pre-reset ram_we", ram_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid-reset gnt1", gnt1, 0);
        chk("mid-reset vld1", vld1, 0);
        chk("mid-reset ram_we", ram_we, 0);
        req1 = 0; we1 = 0; d1 = 0;
        step();
        reset = 1'b1;
        req0 = 1; we0 = 0; addr0 = 8'h10;
        req1 = 1; we1 = 0; addr1 = 8'h20;
        @(negedge clock);
        chk("post-reset idle gnt0", gnt0, 0);
        chk("post-reset idle gnt1", gnt1, 0);
        g1cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            @(negedge clock);
            if (c == 1) chk("post-reset first gnt0", gnt0, 1);
            if (gnt1) g1cnt++;
        end
`ifdef RAM_ARB_FIXED_PRIO_EN
        chk("contention gnt1 cycles", g1cnt, 0);
`else
        chk("contention gnt1 cycles", g1cnt, 4);
`endif
        req0 = 0; req1 = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter for the single-port data RAM. Port 0 is the CPU load/store path (controller-issued addr/we, rs0 data). Port 1 is the io loader/DMA path (io_din bursts). It grants ownership per burst, round-robin between the two ports, with a burst-length cap for fairness, and drives the shared RAM address/data/write-enable from the current owner.

Parameters:
BIT, 16, data width (matches BIT_DATA)
SZB, 8, RAM address width (matches SZB_RAM)
MAX_BURST, 8, max accepted beats per ownership when the other port is waiting (>=1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 request; held until accepted
we0  input  1  port 0 write enable (1=write, 0=read)
addr0  input  SZB  port 0 address
d0  input  BIT  port 0 write data
gnt0  output  1  port 0 owns RAM this cycle
q0  output  BIT  read data (ram_q broadcast)
vld0  output  1  q0 valid for port 0 read accepted previous cycle
req1, we1, addr1, d1, gnt1, q1, vld1  as port 0, for port 1
ram_we  output  1  RAM write enable
ram_addr  output  SZB  RAM address
ram_d  output  BIT  RAM write data
ram_q  input  BIT  RAM read data, valid one cycle after address

Behaviour:
- Reset (reset=0, async): state=IDLE, rr=0 (port 0 preferred), burst count=0, gnt0/gnt1=0, vld0/vld1=0. In-flight read is dropped.
- States: IDLE, OWN0, OWN1. gnt0=(state==OWN0) and gnt1=(state==OWN1), both decoded from registered state. Never both high.
- IDLE: only reqX -> OWNX next edge. Both -> port rr, then rr flips. Neither -> stay.
- Beat accepted when reqX && gntX in the same cycle. The owner's RAM signals are muxed combinationally: ram_addr=addrX, ram_d=dX, ram_we=reqX&gntX&weX.
- When no beat is accepted: ram_we=0, ram_addr=0, ram_d=0.
- Read latency: read beat accepted at cycle N -> vldX=1 at N+1, qX=ram_q. Writes produce no vld.
- Burst count increments per accepted beat. It clears on any ownership change.
- OWNX with !reqX -> other port if it requests, else IDLE.
- OWNX with reqX, other requesting, and count==MAX_BURST-1 with a beat accepted this cycle -> OWN(other), count=0. The preempted port keeps req high and waits.
- OWNX with reqX and other idle -> stay. The count saturates at MAX_BURST-1 (no wrap).
- A port that drops req while not granted loses nothing. A change of addr/d/we while not granted is ignored.
- Handover costs zero bubble cycles for OWN->OWN and one cycle through IDLE.
- Every grant moves rr to the opposite of the port just granted.
- Reset mid-burst: immediate IDLE. ram_we falls combinationally with gnt.

Optional Feature:
RAM_ARB_FIXED_PRIO_EN
- Defined: port 0 always wins arbitration, and the MAX_BURST cap applies only to port 1. Port 1 is preempted after MAX_BURST beats whenever req0=1; port 0 is never preempted.
- Undefined: round-robin with a symmetric cap, as above.

Decomposition:
- definitions.v gains RAM_ARB_IDLE/OWN0/OWN1 state encodings (2-bit) and the default MAX_BURST constant. It reuses BIT_DATA, SZB_RAM and OFF.
- One natural sub-module: ram_arb_mux (owner-select mux for addr/d/we). Everything else stays flat.

Test Plan:
- Port 0 only, write 0xBEEF @0x10, then read @0x10 -> gnt0 one cycle after req0; vld0=1 the cycle after the read beat with q0=0xBEEF; gnt1 stays 0.
- req0 and req1 asserted together from reset -> OWN0 first (rr=0). req0 drops after 2 beats -> OWN1 next edge with no bubble; the next simultaneous contest goes to port 0.
- MAX_BURST=4, port 1 holds a long read burst while req0 rises -> port 1 gets exactly 4 beats, then gnt0 rises. Port 1 resumes when port 0 releases.
- Reset pulled low during an OWN1 read beat -> gnt1, vld1 and ram_we are 0 immediately. After release, state IDLE and the next request is served as from reset.
- Write collision: port 0 writes 0x1111 and port 1 writes 0x2222 to 0x20 -> the RAM holds the value of the later-granted port; a readback confirms 0x2222 when port 0 was granted first.
- RAM_ARB_FIXED_PRIO_EN defined, both ports requesting continuously -> port 0 is held indefinitely; port 1 is never granted while req0=1.
